// File: rtl/uart_pkg.sv
// Shared definitions for the key-to-UART link (transmitter and receiver).
package uart_pkg;

    // Receiver / transmitter frame state encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // One-hot key codes sent by the transmitter
    localparam logic [7:0] KEY0 = 8'h01;
    localparam logic [7:0] KEY1 = 8'h02;
    localparam logic [7:0] KEY2 = 8'h04;
    localparam logic [7:0] KEY3 = 8'h08;

    // A byte carries a key image only when its upper nibble is clear
    function automatic logic is_key_code(input logic [DATA_BITS-1:0] b);
        return (b[DATA_BITS-1:4] == '0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1 (line idle).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_key_rx.sv
// UART 8N1 receiver: single mid-bit sample per bit, start-glitch rejection,
// framing-error flag with break hold-off, and a registered 4-bit key image.
module uart_key_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic [3:0]           key_out,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    logic                 rxs;
    uart_state_t          state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2:0]           idx_reg, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg;
    logic                 frame_err_reg;
    logic [3:0]           key_reg;
    logic                 load_ok;
    logic                 load_err;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath-next logic; all decisions use the synchronized line
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        load_ok    = 1'b0;
        load_err   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                // Half a bit in: a line that is high again was only a glitch
                if (cnt_reg == CNT_HALF) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift_reg[DATA_BITS-1:1]};
                    if (idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaves half a bit early so an immediate next start bit is caught
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rxs) begin
                        load_ok    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        load_err   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line must return high before a new start is accepted
                cnt_next = '0;
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: bit timing, shift register, result and key image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            key_reg       <= 4'b0000;
        end else begin
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            rx_valid_reg  <= load_ok;
            frame_err_reg <= load_err;
            if (load_ok) begin
                rx_data_reg <= shift_reg;
                if (is_key_code(shift_reg)) begin
                    key_reg <= shift_reg[3:0];
                end
            end
        end
    end

    // Output decode
    always_comb begin
        busy      = (state_reg != IDLE);
        rx_data   = rx_data_reg;
        rx_valid  = rx_valid_reg;
        frame_err = frame_err_reg;
        key_out   = key_reg;
    end

endmodule

// File: doc/uart_key_rx.md
Name: uart_key_rx

Overview:
- UART 8N1 receiver that decodes the key codes sent by the key-to-UART transmitter and drives a registered 4-bit key/LED image.
- Sits at the far end of the serial link from the transmitter: board-level demo target, and the loopback checker in transmitter benches.
- Samples once per bit at mid-bit (no oversampling vote), flags framing errors, and rejects start-bit glitches.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208), clocks per bit; benches override to 16. Must be at least 4.

Ports:
- clk  input  1  system clock, 50 MHz nominal.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rx_data  output  8  last correctly framed byte.
- rx_valid  output  1  one-cycle pulse; rx_data is new this cycle.
- frame_err  output  1  one-cycle pulse; stop bit was sampled low.
- key_out  output  4  decoded key image.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release) sets outputs and state: rx_data=0x00, rx_valid=0, frame_err=0, key_out=4'b0000, busy=0, state IDLE, both synchronizer flops=1.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized signal rxs, which lags rx by 2 cycles.
- Bit counter cnt is wide enough for CLKS_PER_BIT-1. The bit index idx counts 0..7.
- IDLE: when rxs==0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==CLKS_PER_BIT/2-1, sample rxs:
  - rxs==1 is a glitch: return to IDLE with no output.
  - rxs==0: go to DATA with cnt=0, idx=0.
- DATA: at cnt==CLKS_PER_BIT-1, shift rxs into the shift register LSB-first and set cnt=0. After idx==7 is sampled, go to STOP; otherwise idx increments.
- STOP: at cnt==CLKS_PER_BIT-1, sample rxs:
  - rxs==1: next cycle load rx_data from the shift register, pulse rx_valid, return to IDLE.
  - rxs==0: next cycle pulse frame_err, leave rx_data unchanged, go to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. This prevents a held-low line from retriggering.
- Key decode happens in the same cycle as the rx_valid pulse:
  - Byte 0x00..0x0F: key_out = byte[3:0].
  - Any other byte: key_out holds its value; rx_valid still pulses.
- Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx start edge, within ±1 cycle of edge alignment.
- Back-to-back frames: the receiver is back in IDLE half a bit before the stop bit ends, so a start bit arriving immediately after the stop bit is caught with no gap required.
- rx changing mid-bit away from the sample point has no effect. Only the single mid-bit sample counts.
- Reset asserted mid-frame aborts immediately; no pulse is emitted. After release, a partial frame in flight is seen as a start only on a falling edge or low level. A resulting framing error is acceptable and not suppressed.
- rx_valid and frame_err are never high in the same cycle.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE, START, DATA, STOP, BREAK;
  - DATA_BITS=8;
  - key code constants KEY0=0x01, KEY1=0x02, KEY2=0x04, KEY3=0x08.
- The transmitter is to import the same package.
- One sub-module: sync_2ff (2-flop synchronizer, reset value 1). Everything else lives in uart_key_rx.

Test Plan (CLKS_PER_BIT=16, 20 ns clock):
- Reset, then idle line for 100 cycles -> all outputs 0, busy 0, no pulses.
- Send frame 0x04 -> one rx_valid pulse ~155 cycles after start edge, rx_data=0x04, key_out=4'b0100, frame_err never high.
- Send 0x01, 0x02, 0x08, 0x00 back-to-back with no idle gap -> four rx_valid pulses in order, key_out sequence 0001, 0010, 1000, 0000.
- Send 0xA5 with stop bit forced low, then line held low 40 cycles, then high, then 0x03 -> one frame_err pulse and no rx_valid for the first frame; rx_data and key_out unchanged; then rx_valid with rx_data=0x03, key_out=0011.
- Low glitch on rx lasting 5 cycles -> busy pulses briefly, then IDLE; no rx_valid or frame_err.
- Assert rst during data bit 3 of a frame -> outputs return to reset values asynchronously; the next clean frame 0x02 is received correctly. Also send 0x41 -> rx_valid with rx_data=0x41, key_out unchanged.
